// File: rtl/serial_twos_complement_array_pkg.sv
// ----------------------------------------------------------------------------
// serial_twos_complement_array_pkg
//   Shared definitions for the multi-channel serial two's complementer:
//   default geometry, frame FSM encoding and the per-bit control bundle that
//   the top broadcasts to every lane.
// ----------------------------------------------------------------------------
package serial_twos_complement_array_pkg;

    localparam int TC_WIDTH    = 8;   // bits per frame
    localparam int TC_CHANNELS = 2;   // parallel lanes

    // Frame FSM encoding
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } tc_state_e;

    // Per-bit control shared by all lanes
    typedef struct packed {
        logic acc;    // a bit is consumed this cycle
        logic first;  // consumed bit is bit 0 of a new frame
        logic last;   // consumed bit is bit WIDTH-1 of the frame
    } lane_ctl_t;

endpackage

// File: rtl/serial_twos_complement_array_lane.sv
// ----------------------------------------------------------------------------
// serial_twos_complement_array_lane
//   One lane of the serial two's complementer. Holds the mode and seen-one
//   flops, the Mealy bit logic (copy up to and including the first 1, invert
//   after it when negating), the LSB-first shift register that deserialises
//   the result, and the overflow detect.
//
// Ports
//   clk_i      in   1      clock, rising edge
//   rst_i      in   1      asynchronous reset, active high
//   ctl_i      in   struct per-bit control from the frame FSM
//   x_i        in   1      serial input bit
//   neg_en_i   in   1      mode, only sampled on the first bit of a frame
//   y_o        out  1      registered result bit (0 when no bit consumed)
//   word_o     out  WIDTH  last completed result word
//   ovf_o      out  1      last completed frame negated -2^(WIDTH-1)
// ----------------------------------------------------------------------------
module serial_twos_complement_array_lane
    import serial_twos_complement_array_pkg::*;
#(
    parameter int WIDTH = TC_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  lane_ctl_t        ctl_i,
    input  logic             x_i,
    input  logic             neg_en_i,
    output logic             y_o,
    output logic [WIDTH-1:0] word_o,
    output logic             ovf_o
);

    logic             mode_q;
    logic             seen_q;
    logic [WIDTH-1:0] shift_q;
    logic             y_q;
    logic [WIDTH-1:0] word_q;
    logic             ovf_q;

    logic             mode_d;
    logic             seen_d;
    logic             ybit;
    logic [WIDTH-1:0] shift_d;

    // Mode and seen-one restart on the first bit so a new frame never
    // inherits state from an interrupted one.
    always_comb begin
        mode_d  = ctl_i.first ? neg_en_i : mode_q;
        seen_d  = ctl_i.first ? 1'b0     : seen_q;
        ybit    = (mode_d & seen_d) ? ~x_i : x_i;
        shift_d = {ybit, shift_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q  <= 1'b0;
            seen_q  <= 1'b0;
            shift_q <= '0;
            y_q     <= 1'b0;
            word_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            y_q <= ctl_i.acc & ybit;
            if (ctl_i.acc) begin
                mode_q  <= mode_d;
                seen_q  <= seen_d | x_i;
                shift_q <= shift_d;
                // Publish only on a completed frame; a dropped partial frame
                // leaves the previous word and ovf untouched.
                if (ctl_i.last) begin
                    word_q <= shift_d;
                    // Input and result MSB both set while negating happens
                    // only for 100..0.
                    ovf_q  <= mode_d & x_i & ybit;
                end
            end
        end
    end

    assign y_o    = y_q;
    assign word_o = word_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/serial_twos_complement_array.sv
// ----------------------------------------------------------------------------
// serial_twos_complement_array
//   Multi-channel, word-framed serial two's complementer. CHANNELS lanes each
//   take an LSB-first serial word of WIDTH bits and either pass it through or
//   negate it. Produces a registered serial result, a deserialised parallel
//   word per lane, per-lane overflow and a framing-error pulse.
//
// Ports
//   t_clock     in   1               clock, rising edge
//   r           in   1               asynchronous reset, active high
//   x           in   CHANNELS        serial input bit per lane, LSB first
//   x_valid     in   1               qualifies x
//   x_first     in   1               with x_valid: bit 0 of a new frame
//   neg_en      in   CHANNELS        per-lane mode, sampled on the first bit
//   y           out  CHANNELS        serial result bit per lane
//   y_valid     out  1               y holds a result bit
//   y_last      out  1               y is bit WIDTH-1 of the frame
//   word        out  CHANNELS*WIDTH  parallel result, lane k at [k*WIDTH +: WIDTH]
//   word_valid  out  1               pulse: word updated this cycle
//   ovf         out  CHANNELS        per-lane negation overflow, with word
//   frame_err   out  1               pulse: x_first arrived mid-frame
// ----------------------------------------------------------------------------
module serial_twos_complement_array
    import serial_twos_complement_array_pkg::*;
#(
    parameter int WIDTH    = TC_WIDTH,
    parameter int CHANNELS = TC_CHANNELS
) (
    input  logic                      t_clock,
    input  logic                      r,
    input  logic [CHANNELS-1:0]       x,
    input  logic                      x_valid,
    input  logic                      x_first,
    input  logic [CHANNELS-1:0]       neg_en,
    output logic [CHANNELS-1:0]       y,
    output logic                      y_valid,
    output logic                      y_last,
    output logic [CHANNELS*WIDTH-1:0] word,
    output logic                      word_valid,
    output logic [CHANNELS-1:0]       ovf,
    output logic                      frame_err
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    tc_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          y_valid_q, y_last_q, word_valid_q, frame_err_q;

    logic          start;
    logic          accept;
    logic          last;
    logic          ferr;
    logic [CW-1:0] idx;
    lane_ctl_t     ctl;

    // Frame control. A first bit always restarts the frame, so a mid-frame
    // x_first flags an error and becomes bit 0 of the new frame.
    always_comb begin
        start   = x_valid & x_first;
        accept  = x_valid & (x_first | (state_q == ST_ACTIVE));
        idx     = start ? '0 : cnt_q;
        last    = accept & (idx == LAST_IDX);
        ferr    = start & (state_q == ST_ACTIVE) & (cnt_q != '0);

        state_d = state_q;
        cnt_d   = cnt_q;
        if (accept) begin
            if (last) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                state_d = ST_ACTIVE;
                cnt_d   = idx + CW'(1);
            end
        end

        ctl.acc   = accept;
        ctl.first = start;
        ctl.last  = last;
    end

    always_ff @(posedge t_clock or posedge r) begin
        if (r) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            y_valid_q    <= 1'b0;
            y_last_q     <= 1'b0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            y_valid_q    <= accept;
            y_last_q     <= last;
            word_valid_q <= last;
            frame_err_q  <= ferr;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        serial_twos_complement_array_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk_i    (t_clock),
            .rst_i    (r),
            .ctl_i    (ctl),
            .x_i      (x[k]),
            .neg_en_i (neg_en[k]),
            .y_o      (y[k]),
            .word_o   (word[k*WIDTH +: WIDTH]),
            .ovf_o    (ovf[k])
        );
    end

    assign y_valid    = y_valid_q;
    assign y_last     = y_last_q;
    assign word_valid = word_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_serial_twos_complement_array.sv
module tb_serial_twos_complement_array;

    localparam int W = 8;
    localparam int C = 2;

    logic           t_clock = 1'b0;
    logic           r;
    logic [C-1:0]   x;
    logic           x_valid;
    logic           x_first;
    logic [C-1:0]   neg_en;
    logic [C-1:0]   y;
    logic           y_valid;
    logic           y_last;
    logic [C*W-1:0] word;
    logic           word_valid;
    logic [C-1:0]   ovf;
    logic           frame_err;

    serial_twos_complement_array #(.WIDTH(W), .CHANNELS(C)) dut (
        .t_clock    (t_clock),
        .r          (r),
        .x          (x),
        .x_valid    (x_valid),
        .x_first    (x_first),
        .neg_en     (neg_en),
        .y          (y),
        .y_valid    (y_valid),
        .y_last     (y_last),
        .word       (word),
        .word_valid (word_valid),
        .ovf        (ovf),
        .frame_err  (frame_err)
    );

    always #70 t_clock = ~t_clock;

    typedef struct {
        logic [1:0]  y;
        logic        last;
        logic        err;
        logic [15:0] word;
        logic [1:0]  ovf;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   compared   = 0;
    int   mismatched = 0;
    int   wv_cnt     = 0;
    int   low_run    = 0;
    int   last_gap   = 0;
    int   wv0        = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Output monitor: pops the scoreboard on every valid result bit.
    always @(negedge t_clock) begin
        if (!r) begin
            if (y_valid) begin
                if (low_run > 0) last_gap = low_run;
                low_run = 0;
                if (word_valid) wv_cnt++;
                if (q.size() == 0) begin
                    chk("unexpected_y_valid", 32'(y_valid), 32'd0);
                end else begin
                    mon_e = q.pop_front();
                    chk("y", 32'(y), 32'(mon_e.y));
                    chk("y_last", 32'(y_last), 32'(mon_e.last));
                    chk("frame_err", 32'(frame_err), 32'(mon_e.err));
                    chk("word_valid", 32'(word_valid), 32'(mon_e.last));
                    if (mon_e.last) begin
                        chk("word", 32'(word), 32'(mon_e.word));
                        chk("ovf", 32'(ovf), 32'(mon_e.ovf));
                    end
                end
            end else begin
                low_run++;
                chk("y_idle", 32'(y), 32'd0);
                chk("word_valid_idle", 32'(word_valid), 32'd0);
                chk("frame_err_idle", 32'(frame_err), 32'd0);
            end
        end
    end

    // Drive one accepted bit and push its expected result.
    task automatic put_bit(input int i, input logic [7:0] a0, input logic [7:0] a1,
                           input logic n0, input logic n1, input logic first, input logic err);
        logic [7:0] r0, r1;
        exp_t e;
        r0 = n0 ? (~a0 + 8'd1) : a0;
        r1 = n1 ? (~a1 + 8'd1) : a1;
        x_valid = 1'b1;
        x_first = first;
        x       = {a1[i], a0[i]};
        neg_en  = first ? {n1, n0} : 2'($urandom);
        e.y     = {r1[i], r0[i]};
        e.last  = (i == 7);
        e.err   = err;
        e.word  = {r1, r0};
        e.ovf   = {n1 && (a1 == 8'h80), n0 && (a0 == 8'h80)};
        q.push_back(e);
        @(posedge t_clock); #1;
    endtask

    task automatic idle(input int n);
        x_valid = 1'b0;
        repeat (n) begin
            x_first = 1'($urandom);
            x       = 2'($urandom);
            neg_en  = 2'($urandom);
            @(posedge t_clock); #1;
        end
    endtask

    task automatic frame(input logic [7:0] a0, input logic [7:0] a1, input logic n0, input logic n1);
        for (int i = 0; i < 8; i++) put_bit(i, a0, a1, n0, n1, (i == 0), 1'b0);
    endtask

    initial begin
        r = 1'b1; x = '0; x_valid = 1'b0; x_first = 1'b0; neg_en = '0;
        @(posedge t_clock); #1;
        @(posedge t_clock); #1;
        chk("rst_y_valid", 32'(y_valid), 32'd0);
        chk("rst_word", 32'(word), 32'd0);
        chk("rst_word_valid", 32'(word_valid), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        r = 1'b0;
        idle(1);

        // Tests 1-3: contiguous back-to-back frames
        frame(8'h06, 8'h5A, 1'b1, 1'b0);   // 0xFA / 0x5A
        frame(8'h80, 8'h80, 1'b1, 1'b0);   // 0x80 ovf / 0x80 no ovf in pass
        frame(8'h00, 8'h33, 1'b1, 1'b1);   // 0x00 no ovf / 0xCD
        idle(2);

        // Non-first bits while idle are ignored (no result pushed)
        x_valid = 1'b1; x_first = 1'b0; x = 2'b11;
        repeat (2) begin @(posedge t_clock); #1; end
        idle(2);

        // Test 4: 3-cycle stall after bit 3
        for (int i = 0; i < 4; i++) put_bit(i, 8'h01, 8'hC3, 1'b1, 1'b0, (i == 0), 1'b0);
        idle(3);
        for (int i = 4; i < 8; i++) put_bit(i, 8'h01, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        chk("stall_gap_len", 32'(last_gap), 32'd3);

        // Test 5: x_first re-asserted at bit 4
        wv0 = wv_cnt;
        for (int i = 0; i < 4; i++) put_bit(i, 8'h55, 8'hAA, 1'b1, 1'b0, (i == 0), 1'b0);
        put_bit(0, 8'h03, 8'h96, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 1; i < 8; i++) put_bit(i, 8'h03, 8'h96, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        chk("ferr_word_valid_count", 32'(wv_cnt - wv0), 32'd1);

        // Test 6: asynchronous reset mid-frame
        for (int i = 0; i < 3; i++) put_bit(i, 8'h11, 8'h22, 1'b1, 1'b0, (i == 0), 1'b0);
        x_valid = 1'b0;
        @(negedge t_clock);
        #20 r = 1'b1;
        #1;
        chk("arst_y_valid", 32'(y_valid), 32'd0);
        chk("arst_y", 32'(y), 32'd0);
        chk("arst_y_last", 32'(y_last), 32'd0);
        chk("arst_word", 32'(word), 32'd0);
        chk("arst_word_valid", 32'(word_valid), 32'd0);
        chk("arst_ovf", 32'(ovf), 32'd0);
        chk("arst_frame_err", 32'(frame_err), 32'd0);
        #30 r = 1'b0;
        frame(8'h7F, 8'h00, 1'b1, 1'b1);   // 0x81 / 0x00
        idle(3);

        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
